// File: rtl/iline_fill_responder_pkg.sv
// Shared types and derived constants for the instruction line-fill responder.
package ceres_param;

  localparam int XLEN      = 32;
  localparam int BLK_SIZE  = 128;
  localparam int IL_WORDS  = BLK_SIZE / XLEN;
  localparam int IL_IDX_W  = $clog2(IL_WORDS);
  localparam int IL_OFF_W  = $clog2(BLK_SIZE / 8);
  localparam int IL_BYTE_W = $clog2(XLEN / 8);
  localparam int IL_CNT_W  = IL_IDX_W + 1;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic            uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } ilowX_res_t;

  typedef enum logic [1:0] {
    IL_IDLE,
    IL_FILL,
    IL_RESP,
    IL_DRAIN
  } iline_fill_state_e;

  function automatic logic [IL_IDX_W-1:0] il_word_idx(input logic [XLEN-1:0] addr);
    return addr[IL_OFF_W-1:IL_BYTE_W];
  endfunction

endpackage

// File: rtl/iline_fill_responder_word_seq.sv
// Issue/receive word sequencing and outstanding-read credit for one line fill.
module iline_word_seq
  import ceres_param::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [IL_IDX_W-1:0] start,
  input  logic                issue_inc,
  input  logic                recv_inc,
  output logic [IL_IDX_W-1:0] issue_idx,
  output logic [IL_IDX_W-1:0] recv_idx,
  output logic [IL_CNT_W-1:0] issued,
  output logic [IL_CNT_W-1:0] received,
  output logic [IL_CNT_W-1:0] inflight
);

  logic [IL_IDX_W-1:0] start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued   <= '0;
      received <= '0;
      inflight <= '0;
      start_q  <= '0;
    end else if (clear) begin
      issued   <= '0;
      received <= '0;
      inflight <= '0;
      start_q  <= start;
    end else begin
      if (issue_inc) issued <= issued + 1'b1;
      if (recv_inc) received <= received + 1'b1;
      if (issue_inc && !recv_inc)      inflight <= inflight + 1'b1;
      else if (!issue_inc && recv_inc) inflight <= inflight - 1'b1;
    end
  end

  // Index arithmetic wraps naturally in IL_IDX_W bits.
  assign issue_idx = start_q + issued[IL_IDX_W-1:0];
  assign recv_idx  = start_q + received[IL_IDX_W-1:0];

endmodule

// File: rtl/iline_fill_responder.sv
// Instruction line-fill responder: fetches a cache line (or one uncached word) over an
// in-order word memory port. Optional critical-word-first ordering via ILINE_CWF_EN.
module iline_fill_responder
  import ceres_param::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  ilowX_req_t      lx_ireq_i,
  output ilowX_res_t      lx_ires_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  localparam logic [IL_CNT_W-1:0] MAX_OS = IL_CNT_W'(MAX_OUTSTANDING);

  iline_fill_state_e            state;
  logic [XLEN-IL_OFF_W-1:0]     line_tag;
  logic [IL_CNT_W-1:0]          beats;
  logic [BLK_SIZE-1:0]          blk;
  logic                         accept;
  logic                         issue_inc;
  logic                         recv_inc;
  logic [IL_IDX_W-1:0]          start_idx;
  logic [IL_IDX_W-1:0]          issue_idx;
  logic [IL_IDX_W-1:0]          recv_idx;
  logic [IL_CNT_W-1:0]          issued;
  logic [IL_CNT_W-1:0]          received;
  logic [IL_CNT_W-1:0]          inflight;
  logic [IL_CNT_W-1:0]          inflight_nxt;
  logic                         unused_ok;

  assign unused_ok = ^lx_ireq_i.addr[IL_BYTE_W-1:0];

`ifdef ILINE_CWF_EN
  assign start_idx = il_word_idx(lx_ireq_i.addr);
`else
  assign start_idx = lx_ireq_i.uncached ? il_word_idx(lx_ireq_i.addr) : '0;
`endif

  assign accept    = (state == IL_IDLE) && lx_ireq_i.valid && lx_ireq_i.ready && !flush_i;
  assign mem_req_o = (state == IL_FILL) && (issued < beats) && (inflight < MAX_OS);
  assign mem_addr_o = mem_req_o ? {line_tag, issue_idx, {IL_BYTE_W{1'b0}}} : '0;
  assign issue_inc = mem_req_o && mem_gnt_i;
  assign recv_inc  = mem_rvalid_i && ((state == IL_FILL) || (state == IL_DRAIN));

  always_comb begin
    inflight_nxt = inflight;
    if (issue_inc && !recv_inc)      inflight_nxt = inflight + 1'b1;
    else if (!issue_inc && recv_inc) inflight_nxt = inflight - 1'b1;
  end

  iline_word_seq u_seq (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (accept),
    .start     (start_idx),
    .issue_inc (issue_inc),
    .recv_inc  (recv_inc),
    .issue_idx (issue_idx),
    .recv_idx  (recv_idx),
    .issued    (issued),
    .received  (received),
    .inflight  (inflight)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IL_IDLE;
      line_tag <= '0;
      beats    <= '0;
      blk      <= '0;
    end else begin
      case (state)
        IL_IDLE: begin
          if (accept) begin
            state    <= IL_FILL;
            line_tag <= lx_ireq_i.addr[XLEN-1:IL_OFF_W];
            beats    <= lx_ireq_i.uncached ? IL_CNT_W'(1) : IL_CNT_W'(IL_WORDS);
            blk      <= '0;
          end
        end
        IL_FILL: begin
          for (int i = 0; i < IL_WORDS; i++)
            if (recv_inc && (recv_idx == IL_IDX_W'(i))) blk[i*XLEN +: XLEN] <= mem_rdata_i;
          // Flush wins over completion; reads still in flight must be drained.
          if (flush_i)
            state <= (inflight_nxt == '0) ? IL_IDLE : IL_DRAIN;
          else if (recv_inc && ((received + 1'b1) == beats))
            state <= IL_RESP;
        end
        IL_RESP:  state <= IL_IDLE;
        IL_DRAIN: if (inflight_nxt == '0) state <= IL_IDLE;
        default:  state <= IL_IDLE;
      endcase
    end
  end

  assign lx_ires_o.valid = (state == IL_RESP);
  assign lx_ires_o.ready = (state == IL_IDLE);
  assign lx_ires_o.blk   = blk;
  assign busy_o          = (state != IL_IDLE);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (!rst_i && (state == IL_IDLE))
      assert (!mem_rvalid_i) else $error("mem_rvalid_i asserted while idle");
`endif

endmodule

// File: tb/tb_iline_fill_responder.sv
// Randomized self-checking bench for iline_fill_responder with a behavioural memory/line model.
`timescale 1ns/1ps
module tb_iline_fill_responder;
  import ceres_param::*;

  localparam int MAXO = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_i;
  ilowX_req_t      lx_ireq_i;
  ilowX_res_t      lx_ires_o;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  iline_fill_responder #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .lx_ireq_i    (lx_ireq_i),
    .lx_ires_o    (lx_ires_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [BLK_SIZE-1:0] got, input logic [BLK_SIZE-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: in-order reads, each returned no earlier than the cycle after its grant.
  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } rd_t;

  rd_t             rq[$];
  logic [XLEN-1:0] exp_addr[$];
  int              gnt_pct = 100;
  int              stall_left = 0;
  int              dly_min = 0;
  int              dly_max = 0;
  int              last_rv_cyc = -1;
  int              mm_pre;
  logic            mm_g;
  logic [XLEN-1:0] salt = 32'h1234_5678;
  logic            force_en = 1'b0;
  logic [XLEN-1:0] force_val = '0;
  logic            prev_wait = 1'b0;
  logic [XLEN-1:0] prev_addr = '0;

  function automatic logic [XLEN-1:0] memword(input logic [XLEN-1:0] a);
    if (force_en) return force_val;
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  initial begin
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      if (rst_i) begin
        rq.delete();
        prev_wait = 1'b0;
      end else begin
        mm_pre = rq.size();
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = memword(rq[0].addr);
          last_rv_cyc = cyc;
          void'(rq.pop_front());
        end
        if (mem_req_o) begin
          if (prev_wait) chk("addr_hold", mem_addr_o, prev_addr);
          if (stall_left > 0) begin
            stall_left--;
            mm_g = 1'b0;
          end else begin
            mm_g = ($urandom_range(99, 0) < gnt_pct);
          end
          if (mm_g) begin
            mem_gnt_i = 1'b1;
            prev_wait = 1'b0;
            chk("outstanding_le_max", (mm_pre + 1 <= MAXO), 1);
            chk("read_expected", (exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) chk("read_addr", mem_addr_o, exp_addr.pop_front());
            rq.push_back('{addr: mem_addr_o, due: cyc + 1 + $urandom_range(dly_max, dly_min)});
          end else begin
            prev_wait = 1'b1;
            prev_addr = mem_addr_o;
          end
        end else begin
          prev_wait = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, lx_ires_o.valid, 0);
    chk({tag, "_ready"}, lx_ires_o.ready, 1);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_blk"}, lx_ires_o.blk, 0);
  endtask

  // Build the expected read order and line from the address, then push the request.
  task automatic start_req(input logic [XLEN-1:0] a, input logic u, output logic [BLK_SIZE-1:0] eblk,
                           output int acc);
    logic [XLEN-1:0] base;
    int widx;
    int st;
    int idx;
    base = (a / (BLK_SIZE / 8)) * (BLK_SIZE / 8);
    widx = int'((a % (BLK_SIZE / 8)) / (XLEN / 8));
    eblk = '0;
    if (u) begin
      exp_addr.push_back((a / (XLEN / 8)) * (XLEN / 8));
      eblk[widx*XLEN +: XLEN] = memword((a / (XLEN / 8)) * (XLEN / 8));
    end else begin
`ifdef ILINE_CWF_EN
      st = widx;
`else
      st = 0;
`endif
      for (int n = 0; n < IL_WORDS; n++) begin
        idx = (st + n) % IL_WORDS;
        exp_addr.push_back(base + XLEN'(idx * (XLEN / 8)));
      end
      for (int i = 0; i < IL_WORDS; i++) eblk[i*XLEN +: XLEN] = memword(base + XLEN'(i * (XLEN / 8)));
    end
    lx_ireq_i = '{valid: 1'b1, ready: 1'b1, addr: a, uncached: u};
    acc = cyc;
    @(negedge clk);
    lx_ireq_i.valid = 1'b0;
    chk("ready_after_accept", lx_ires_o.ready, 0);
    chk("busy_after_accept", busy_o, 1);
  endtask

  task automatic do_fill(input logic [XLEN-1:0] a, input logic u, input int exp_lat);
    logic [BLK_SIZE-1:0] eblk;
    int acc;
    int t;
    t = 0;
    while (!lx_ires_o.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_req", lx_ires_o.ready, 1);
    start_req(a, u, eblk, acc);
    t = 0;
    while (!lx_ires_o.valid && t < 300) begin
      if (lx_ires_o.ready) chk("ready_low_during_fill", lx_ires_o.ready, 0);
      @(negedge clk);
      t++;
    end
    chk("resp_seen", lx_ires_o.valid, 1);
    if (lx_ires_o.valid) begin
      chk("resp_blk", lx_ires_o.blk, eblk);
      chk("ready_in_resp", lx_ires_o.ready, 0);
      if (exp_lat >= 0) chk("latency", cyc - acc, exp_lat);
      @(negedge clk);
      chk("valid_single_pulse", lx_ires_o.valid, 0);
      chk("ready_after_resp", lx_ires_o.ready, 1);
    end
    chk("all_reads_issued", exp_addr.size(), 0);
  endtask

  logic [BLK_SIZE-1:0] blk1;
  logic [BLK_SIZE-1:0] eb;
  int                  acc0;
  int                  tw;
  logic                saw_valid;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    lx_ireq_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // 1: cached fill, zero-wait memory
    do_fill(32'h8000_0014, 1'b0, IL_WORDS + 2);
    blk1 = lx_ires_o.blk;

    // 2: uncached word into its own lane
    force_en = 1'b1;
    force_val = 32'hDEAD_BEEF;
    do_fill(32'h2000_0008, 1'b0 | 1'b1, 3);
    chk("unc_lane2", lx_ires_o.blk[95:64], 32'hDEAD_BEEF);
    force_en = 1'b0;

    // 3: first beat held off by 5 ungranted cycles
    stall_left = 5;
    do_fill(32'h8000_0014, 1'b0, IL_WORDS + 2 + 5);

    // 4: slow read return exercising the credit limit
    dly_min = 3;
    dly_max = 3;
    do_fill(32'h8000_0014, 1'b0, -1);
    dly_min = 0;
    dly_max = 0;

    // Same line from a different word: identical block in either issue order
    do_fill(32'h8000_0018, 1'b0, IL_WORDS + 2);
    chk("same_line_blk", lx_ires_o.blk, blk1);

    // Flush in IDLE blocks acceptance
    lx_ireq_i = '{valid: 1'b1, ready: 1'b1, addr: 32'h8000_0100, uncached: 1'b0};
    flush_i = 1'b1;
    @(negedge clk);
    lx_ireq_i.valid = 1'b0;
    flush_i = 1'b0;
    chk("idle_flush_busy", busy_o, 0);
    chk("idle_flush_req", mem_req_o, 0);

    // 5: flush after two grants, nothing returned yet
    dly_min = 8;
    dly_max = 8;
    start_req(32'h8000_0020, 1'b0, eb, acc0);
    tw = 0;
    while (rq.size() < 2 && tw < 50) begin
      @(negedge clk);
      tw++;
    end
    chk("two_granted", rq.size(), 2);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("drain_busy", busy_o, 1);
    chk("drain_req_low", mem_req_o, 0);
    chk("drain_ready_low", lx_ires_o.ready, 0);
    saw_valid = 1'b0;
    tw = 0;
    while (!lx_ires_o.ready && tw < 100) begin
      if (lx_ires_o.valid) saw_valid = 1'b1;
      @(negedge clk);
      tw++;
    end
    chk("drain_no_valid", saw_valid, 0);
    chk("drain_ready_timing", cyc, last_rv_cyc + 1);
    chk("drain_reads_consumed", rq.size(), 0);
    chk("drain_reads_issued", exp_addr.size(), 2);
    exp_addr.delete();
    dly_min = 0;
    dly_max = 0;
    do_fill(32'h8000_0030, 1'b0, IL_WORDS + 2);

    // 6: reset in the middle of a fill
    dly_min = 1;
    dly_max = 1;
    start_req(32'h8000_0018, 1'b0, eb, acc0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_outputs("midfill_reset");
    exp_addr.delete();
    dly_min = 0;
    dly_max = 0;
    do_fill(32'h8000_001C, 1'b0, IL_WORDS + 2);

    // Randomized fills with random grant gaps and return delays
    for (int k = 0; k < 24; k++) begin
      salt = $urandom;
      gnt_pct = $urandom_range(100, 50);
      dly_min = 0;
      dly_max = $urandom_range(3, 0);
      do_fill($urandom, 1'($urandom_range(1, 0)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iline_fill_responder.md
Name: iline_fill_responder

Overview:
- Responder end of the instruction lower-level (ilowX) request/response interface driven by the instruction cache.
- Accepts one line-fill or uncached request at a time.
- Fetches the line as XLEN-wide word reads over a simple in-order memory port, assembles a BLK_SIZE-bit block and returns it with a one-cycle valid pulse.
- Sits between the icache lowX port and the instruction memory/bus bridge.

Parameters:
XLEN, 32, word width and memory data width
BLK_SIZE, 128, line width in bits; BLK_SIZE/XLEN words per line, power of two, >=2
MAX_OUTSTANDING, 2, maximum granted-but-unreturned memory reads (1..4)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
flush_i  input  1  abort current fill; no response is returned for it
lx_ireq_i  input  ilowX_req_t  request: valid, ready, addr[XLEN-1:0], uncached
lx_ires_o  output  ilowX_res_t  response: valid, ready, blk[BLK_SIZE-1:0]
mem_req_o  output  1  word read request
mem_addr_o  output  XLEN  word-aligned read address
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  read data valid; responses return in issue order
mem_rdata_i  input  XLEN  read data
busy_o  output  1  state != IDLE

Behaviour:
- Reset (rst_i sampled high at posedge): state IDLE, all counters 0, blk register 0, lx_ires_o.valid=0, lx_ires_o.ready=1, mem_req_o=0, mem_addr_o=0. The memory port is reset together with this block, so no stale rvalid arrives after reset.
- States: IDLE, FILL, RESP, DRAIN.
- IDLE:
  - lx_ires_o.ready=1.
  - Accept when lx_ireq_i.valid && ready && !flush_i.
  - Latch line base = addr with low log2(BLK_SIZE/8) bits cleared, and latch the word index.
  - beats = 1 if uncached, else BLK_SIZE/XLEN.
  - Go to FILL next cycle.
  - The request valid is a single-cycle pulse; it is not re-checked after acceptance.
- FILL:
  - ready=0.
  - mem_req_o=1 while issued<beats and inflight<MAX_OUTSTANDING.
  - mem_addr_o = line base + 4*issue_idx. For uncached: mem_addr_o = addr & ~3.
  - mem_addr_o is held stable while mem_req_o && !mem_gnt_i.
  - gnt increments issued and inflight; rvalid decrements inflight and writes mem_rdata_i into lane recv_idx of the blk register. Simultaneous gnt and rvalid leave inflight unchanged.
  - Uncached: lane = addressed word index; all other lanes 0 (register cleared on accept).
  - When received==beats, go to RESP.
- RESP: lx_ires_o.valid=1 for exactly one cycle with blk, ready=0, then IDLE. Minimum latency with zero-wait memory: accept cycle + beats + 2.
- flush_i in FILL:
  - If inflight==0, go to IDLE next cycle.
  - Otherwise go to DRAIN: mem_req_o=0, discard rvalid data until inflight==0, then IDLE.
  - No response is produced.
- flush_i in RESP: valid is still driven that cycle; the requester ignores it.
- flush_i in IDLE: blocks acceptance that cycle.
- Indices wrap modulo BLK_SIZE/XLEN; counters are log2(words)+1 bits wide, with no overflow within a fill.
- Addresses are computed modulo 2^XLEN.
- rvalid in IDLE: ignored. This is a protocol violation; assertion under simulation.

Optional Feature:
- Macro ILINE_CWF_EN: critical-word-first.
  - Defined: cached fills start at the requested word index and wrap (idx = (start+n) mod words). Lane placement always follows the word address, so blk is identical to the linear case.
  - Undefined: cached fills always issue word 0..words-1 in order.
  - Uncached behaviour is the same in both cases.

Decomposition:
- Package ceres_param holds:
  - ilowX_req_t and ilowX_res_t (existing).
  - New iline_fill_state_e enum.
  - Derived constants: IL_WORDS = BLK_SIZE/XLEN, IL_IDX_W = $clog2(IL_WORDS), IL_OFF_W = $clog2(BLK_SIZE/8).
- One sub-module, iline_word_seq: the issue/receive index and credit counter (issued, received, inflight, wrap, CWF start), with increment/clear inputs and index outputs.
- The top-level holds the FSM, the blk register and the ports.

Test Plan:
1. Cached fill, addr 0x8000_0014, zero-wait memory:
   - Expected reads 0x8000_0010, 14, 18, 1C.
   - Expected single valid pulse with blk={w3,w2,w1,w0}.
   - ready=0 from the accept+1 cycle until after RESP.
2. Uncached, addr 0x2000_0008, rdata 0xDEADBEEF:
   - Expected exactly one read at 0x2000_0008.
   - Expected blk[95:64]=0xDEADBEEF and all other bits 0.
3. Backpressure, mem_gnt_i low for 5 cycles on the first beat:
   - mem_req_o stays 1 and mem_addr_o stays 0x8000_0010 throughout.
   - Completion is delayed by exactly 5 cycles.
4. MAX_OUTSTANDING=2, rvalid delayed 3 cycles: no more than 2 granted reads are ever unreturned; the line is still correct.
5. Flush after 2 grants and 0 rvalids:
   - State goes to DRAIN and mem_req_o drops.
   - 2 rvalids are discarded; no valid pulse.
   - ready returns 1 the cycle after the last rvalid.
   - The next request fills correctly.
6. With ILINE_CWF_EN, addr 0x8000_0018: expected read order 18, 1C, 10, 14 and a blk identical to scenario 1. Rerun with rst_i asserted mid-fill: all outputs take their reset values on the next cycle.
